// File: rtl/sseg_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between NREQ requesters.
// Optional macro ARB_PRIO0_EN makes requester 0 urgent (wins in IDLE, preempts other owners).
module sseg_display_arbiter #(
    parameter int NREQ        = 4,
    parameter int HOLD_W      = 24,
    parameter int HOLD_CYCLES = 1000000,
    localparam int OW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] data,
    output logic [NREQ-1:0]    grant,
    output logic [OW-1:0]      owner,
    output logic               busy,
    output logic [15:0]        disp_out
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic [HOLD_W-1:0] ctr;

    logic              any_found;
    logic [OW-1:0]     any_idx;
    logic              other_found;
    logic [OW-1:0]     other_idx;
    logic              load_en;
    logic [OW-1:0]     load_idx;

    // Round-robin search from owner+1 upward; the owner itself is the last candidate.
    always_comb begin
        any_found   = 1'b0;
        any_idx     = owner;
        other_found = 1'b0;
        other_idx   = owner;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = int'(owner) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_found && req[idx]) begin
                any_found = 1'b1;
                any_idx   = OW'(idx);
            end
            if (k < NREQ && !other_found && req[idx]) begin
                other_found = 1'b1;
                other_idx   = OW'(idx);
            end
        end
    end

    always_comb begin
        load_en  = 1'b0;
        load_idx = owner;
        if (state == IDLE) begin
            if (any_found) begin
                load_en  = 1'b1;
                load_idx = any_idx;
            end
        end else if (ctr == '0 && other_found) begin
            load_en  = 1'b1;
            load_idx = other_idx;
        end
`ifdef ARB_PRIO0_EN
        // An owner other than 0 is cut short as soon as requester 0 asks.
        if (req[0] && (state == IDLE || owner != '0)) begin
            load_en  = 1'b1;
            load_idx = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= OW'(NREQ - 1);
            disp_out <= 16'h0000;
            ctr      <= '0;
        end else if (load_en) begin
            state    <= SHOW;
            grant    <= NREQ'(1) << load_idx;
            owner    <= load_idx;
            disp_out <= data[16*load_idx +: 16];
            ctr      <= HOLD_RELOAD;
        end else if (state == SHOW) begin
            if (ctr != '0) ctr <= ctr - 1'b1;
            // Track the owner's live value; once it drops its request the display freezes.
            if (req[owner]) begin
                disp_out <= data[16*owner +: 16];
            end else if (ctr == '0) begin
                state <= IDLE;
                grant <= '0;
            end
        end
    end

    assign busy = (state == SHOW);

endmodule
